// File: rtl/gci_hub_pkg.sv
// Shared definitions for the hub special-memory read arbiter: sizes, FSM encoding and helpers.
// Purely declarative; no logic, latency or flow control of its own.
package gci_hub_pkg;

  localparam int GCI_NODE_NUM = 4;
  localparam int GCI_SMEM_AW  = 10;
  localparam int GCI_SMEM_DW  = 32;

  typedef enum logic [1:0] {
    GCI_SMEM_ARB_IDLE = 2'd0,
    GCI_SMEM_ARB_READ = 2'd1,
    GCI_SMEM_ARB_RESP = 2'd2
  } gci_smem_arb_state_e;

  // Special memory is word-addressed underneath; byte offsets other than 0 are rejected.
  function automatic logic gci_smem_misaligned(input logic [GCI_SMEM_AW-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/gci_hub_smem_rr_picker.sv
// Round-robin picker: first set pend bit at or above rr_ptr, wrapping 3->0.
// Combinational, zero latency; no flow control.
module gci_hub_smem_rr_picker
  import gci_hub_pkg::*;
(
  input  logic [GCI_NODE_NUM-1:0] pend,
  input  logic [1:0]              rr_ptr,
  output logic                    any,
  output logic [1:0]              grant
);

  logic [1:0] idx;

  always_comb begin
    any   = 1'b0;
    grant = rr_ptr;
    idx   = rr_ptr;
    for (int i = 0; i < GCI_NODE_NUM; i++) begin
      idx = rr_ptr + 2'(i);
      if (!any && pend[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/gci_hub_smem_arbiter.sv
// Serialises one outstanding read per node onto the special-memory port; 3 cycles accept->valid at zero wait.
// Requests seen while a node is busy are dropped; memory stalls are bounded by P_TIMEOUT.
module gci_hub_smem_arbiter
  import gci_hub_pkg::*;
#(
  parameter int P_TIMEOUT = 16
)(
  input  logic                   iCLOCK,
  input  logic                   iRESET_SYNC,
  input  logic                   iRD1_REQ,
  input  logic [GCI_SMEM_AW-1:0] iRD1_ADDR,
  output logic                   oRD1_BUSY,
  output logic                   oRD1_VALID,
  output logic                   oRD1_ERR,
  input  logic                   iRD2_REQ,
  input  logic [GCI_SMEM_AW-1:0] iRD2_ADDR,
  output logic                   oRD2_BUSY,
  output logic                   oRD2_VALID,
  output logic                   oRD2_ERR,
  input  logic                   iRD3_REQ,
  input  logic [GCI_SMEM_AW-1:0] iRD3_ADDR,
  output logic                   oRD3_BUSY,
  output logic                   oRD3_VALID,
  output logic                   oRD3_ERR,
  input  logic                   iRD4_REQ,
  input  logic [GCI_SMEM_AW-1:0] iRD4_ADDR,
  output logic                   oRD4_BUSY,
  output logic                   oRD4_VALID,
  output logic                   oRD4_ERR,
  output logic [GCI_SMEM_DW-1:0] oRD_DATA,
  output logic                   oSMEM_REQ,
  output logic [GCI_SMEM_AW-1:0] oSMEM_ADDR,
  input  logic                   iSMEM_VALID,
  input  logic [GCI_SMEM_DW-1:0] iSMEM_DATA
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(P_TIMEOUT - 1);

  logic [GCI_NODE_NUM-1:0] req_in;
  logic [GCI_SMEM_AW-1:0]  addr_in [GCI_NODE_NUM];

  assign req_in     = {iRD4_REQ, iRD3_REQ, iRD2_REQ, iRD1_REQ};
  assign addr_in[0] = iRD1_ADDR;
  assign addr_in[1] = iRD2_ADDR;
  assign addr_in[2] = iRD3_ADDR;
  assign addr_in[3] = iRD4_ADDR;

  gci_smem_arb_state_e     state_q, state_d;
  logic [GCI_NODE_NUM-1:0] pend_q, pend_d;
  logic [GCI_SMEM_AW-1:0]  addr_q [GCI_NODE_NUM];
  logic [1:0]              rr_ptr_q, rr_ptr_d;
  logic [1:0]              grant_q, grant_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [GCI_SMEM_DW-1:0]  data_q, data_d;
  logic                    err_q, err_d;

  logic                    pick_any;
  logic [1:0]              pick_grant;
  logic [GCI_NODE_NUM-1:0] resp_vld, resp_err;
  logic                    smem_req;
  logic [GCI_SMEM_AW-1:0]  smem_addr;

  gci_hub_smem_rr_picker u_picker (
    .pend   (pend_q),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .grant  (pick_grant)
  );

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    err_d     = err_q;
    resp_vld  = '0;
    resp_err  = '0;
    smem_req  = 1'b0;
    smem_addr = '0;

    for (int n = 0; n < GCI_NODE_NUM; n++) begin
      if (req_in[n] && !pend_q[n]) pend_d[n] = 1'b1;
    end

    case (state_q)
      GCI_SMEM_ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_grant;
          if (gci_smem_misaligned(addr_q[pick_grant])) begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = GCI_SMEM_ARB_RESP;
          end else begin
            cnt_d   = '0;
            state_d = GCI_SMEM_ARB_READ;
          end
        end
      end
      GCI_SMEM_ARB_READ: begin
        smem_req  = 1'b1;
        smem_addr = addr_q[grant_q];
        // Data arriving on the last allowed cycle still counts as a hit.
        if (iSMEM_VALID) begin
          data_d  = iSMEM_DATA;
          err_d   = 1'b0;
          state_d = GCI_SMEM_ARB_RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = GCI_SMEM_ARB_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GCI_SMEM_ARB_RESP: begin
        resp_vld[grant_q] = 1'b1;
        resp_err[grant_q] = err_q;
        pend_d[grant_q]   = 1'b0;
        rr_ptr_d          = grant_q + 2'd1;
        state_d           = GCI_SMEM_ARB_IDLE;
      end
      default: state_d = GCI_SMEM_ARB_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q  <= GCI_SMEM_ARB_IDLE;
      pend_q   <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      for (int n = 0; n < GCI_NODE_NUM; n++) addr_q[n] <= '0;
    end else begin
      for (int n = 0; n < GCI_NODE_NUM; n++) begin
        if (req_in[n] && !pend_q[n]) addr_q[n] <= addr_in[n];
      end
    end
  end

  assign oRD1_BUSY  = pend_q[0];
  assign oRD2_BUSY  = pend_q[1];
  assign oRD3_BUSY  = pend_q[2];
  assign oRD4_BUSY  = pend_q[3];
  assign oRD1_VALID = resp_vld[0];
  assign oRD2_VALID = resp_vld[1];
  assign oRD3_VALID = resp_vld[2];
  assign oRD4_VALID = resp_vld[3];
  assign oRD1_ERR   = resp_err[0];
  assign oRD2_ERR   = resp_err[1];
  assign oRD3_ERR   = resp_err[2];
  assign oRD4_ERR   = resp_err[3];
  assign oRD_DATA   = data_q;
  assign oSMEM_REQ  = smem_req;
  assign oSMEM_ADDR = smem_addr;

endmodule
